// File: rtl/mul_seq_pkg.sv
// Package for mul_seq: FSM state type built from the shared encodings,
// default width and counter-width helper.
`include "mul_defs.vh"

package mul_seq_pkg;

    localparam int WIDTH_DEFAULT = `MUL_WIDTH_DEFAULT;

    typedef enum logic [1:0] {
        IDLE = `S_IDLE,
        RUN  = `S_RUN,
        DONE = `S_DONE
    } state_e;

    // Counter must be able to hold the value WIDTH itself without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mul_defs.vh
// Shared definitions for the sequential multiplier: FSM state encodings
// and the default operand width.
`ifndef MUL_DEFS_VH
`define MUL_DEFS_VH

`define MUL_WIDTH_DEFAULT 16

`define S_IDLE 2'b00
`define S_RUN  2'b01
`define S_DONE 2'b10

`endif

// File: rtl/mul_step.sv
// One shift-add iteration of the multiplier: conditionally add the
// multiplicand into the high half (keeping the carry), then shift
// {carry,hi,lo} right by one bit.
module mul_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;

    // Add-if-LSB-set followed by the 1-bit right shift of {carry,hi,lo}.
    always_comb begin
        sum = {1'b0, hi_i};
        if (lo_i[0]) begin
            sum = {1'b0, hi_i} + {1'b0, mcand_i};
        end
        hi_o = sum[WIDTH:1];
        lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier, one bit of the multiplier per cycle,
// fixed latency of WIDTH RUN cycles plus one DONE cycle.
// Optional macro MUL_SEQ_SIGNED_EN adds the sgn input: when sgn=1 the
// operands are two's complement, their magnitudes are multiplied and the
// product is negated on load when the operand signs differ.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef MUL_SEQ_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [2*WIDTH-1:0]  p_q, p_d;

    logic [WIDTH-1:0]    step_hi, step_lo;
    logic [WIDTH-1:0]    a_cap, b_cap;
    logic [2*WIDTH-1:0]  result;
    logic                accept;

`ifdef MUL_SEQ_SIGNED_EN
    logic                neg_q, neg_d;
    logic                a_neg, b_neg;
`endif

    mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .mcand_i (mcand_q),
        .hi_o    (step_hi),
        .lo_o    (step_lo)
    );

    // Operand values to capture on an accepted start, and the product to
    // load into P once the final iteration completes.
`ifdef MUL_SEQ_SIGNED_EN
    always_comb begin
        a_neg  = sgn & A[WIDTH-1];
        b_neg  = sgn & B[WIDTH-1];
        a_cap  = a_neg ? (~A + WIDTH'(1)) : A;
        b_cap  = b_neg ? (~B + WIDTH'(1)) : B;
        result = neg_q ? (~{step_hi, step_lo} + (2*WIDTH)'(1)) : {step_hi, step_lo};
    end
`else
    always_comb begin
        a_cap  = A;
        b_cap  = B;
        result = {step_hi, step_lo};
    end
`endif

    // Next-state, counter and datapath register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_d     = p_q;
`ifdef MUL_SEQ_SIGNED_EN
        neg_d   = neg_q;
`endif
        accept  = start && (state_q == IDLE || state_q == DONE);

        case (state_q)
            RUN: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    p_d     = result;
                    state_d = DONE;
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    mcand_d = a_cap;
                    hi_d    = '0;
                    lo_d    = b_cap;
                    cnt_d   = '0;
`ifdef MUL_SEQ_SIGNED_EN
                    neg_d   = a_neg ^ b_neg;
`endif
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_q     <= '0;
`ifdef MUL_SEQ_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_q     <= p_d;
`ifdef MUL_SEQ_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign P    = p_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: vector table, randomized operands
// against an arithmetic product model, and hand-written sequences for
// ignored start, back-to-back operation and mid-run reset.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
`ifdef MUL_SEQ_SIGNED_EN
    logic        sgn;
`endif
    logic        busy;
    logic        done;
    logic [31:0] P;

    int n_checks = 0;
    int n_fail   = 0;

    mul_seq #(
        .WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef MUL_SEQ_SIGNED_EN
        .sgn   (sgn),
`endif
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Unsigned reference product from plain arithmetic.
    function automatic logic [31:0] model_u(input logic [15:0] a, input logic [15:0] b);
        return 32'(a) * 32'(b);
    endfunction

    // Launch one operation and watch 40 cycles; operands are scrambled
    // during the run, which must not disturb the result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [31:0] p, output int done_idx,
                          output int busy_cnt, output int done_cnt);
        p        = '0;
        done_idx = -1;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        A     = a;
        B     = b;
`ifdef MUL_SEQ_SIGNED_EN
        sgn   = s;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) begin
                    done_idx = n;
                    p        = P;
                end
            end
            A = 16'($urandom);
            B = 16'($urandom);
`ifdef MUL_SEQ_SIGNED_EN
            sgn = 1'($urandom);
`endif
            @(negedge clk);
        end
        if (s) begin end
    endtask

    initial begin
        vec_t        vecs[5];
        logic [31:0] p;
        int          di, bc, dc;
        int          d1, d2;
        logic [31:0] p1, p2;
        logic        gap_busy;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
        vecs[3] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
        vecs[4] = '{16'h8000, 16'h0002, 32'h0001_0000};

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
`ifdef MUL_SEQ_SIGNED_EN
        sgn   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_P", 64'(P), 64'(0));

        // Table-driven vectors
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, p, di, bc, dc);
            $display("vec %0d: A=0x%04h B=0x%04h P=0x%08h done_at=%0d", i, vecs[i].a, vecs[i].b, p, di);
            check("vec_P", 64'(p), 64'(vecs[i].p));
            check("vec_latency", 64'(di), 64'(16));
            check("vec_busy_cycles", 64'(bc), 64'(16));
            check("vec_done_pulses", 64'(dc), 64'(1));
            check("vec_P_hold", 64'(P), 64'(vecs[i].p));
        end

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) rb = 16'h0000;
            run_op(ra, rb, 1'b0, p, di, bc, dc);
            $display("rnd %0d: A=0x%04h B=0x%04h P=0x%08h done_at=%0d", i, ra, rb, p, di);
            check("rnd_P", 64'(p), 64'(model_u(ra, rb)));
            check("rnd_latency", 64'(di), 64'(16));
        end

`ifdef MUL_SEQ_SIGNED_EN
        run_op(16'hFFFE, 16'h0003, 1'b1, p, di, bc, dc);
        $display("sgn: A=0xfffe B=0x0003 P=0x%08h", p);
        check("sgn_neg_pos", 64'(p), 64'(32'hFFFF_FFFA));
        check("sgn_latency", 64'(di), 64'(16));
        run_op(16'h8000, 16'h8000, 1'b1, p, di, bc, dc);
        $display("sgn: A=0x8000 B=0x8000 P=0x%08h", p);
        check("sgn_min_min", 64'(p), 64'(32'h4000_0000));
        run_op(16'hFFFF, 16'hFFFF, 1'b0, p, di, bc, dc);
        $display("sgn0: A=0xffff B=0xffff P=0x%08h", p);
        check("sgn0_unsigned", 64'(p), 64'(32'hFFFE_0001));
`endif

        // Start pulsed during RUN must be ignored; P holds afterwards
        di = -1; dc = 0; bc = 0; p = '0;
        @(negedge clk);
        A = 16'd3; B = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (n == 5) begin A = 16'd7; B = 16'd7; start = 1'b1; end
            if (n == 6) start = 1'b0;
            if (busy) bc++;
            if (done) begin
                dc++;
                if (di < 0) begin di = n; p = P; end
            end
            @(negedge clk);
        end
        $display("ignore: P=0x%08h done_at=%0d pulses=%0d", p, di, dc);
        check("ignore_P", 64'(p), 64'(32'h0000_000F));
        check("ignore_latency", 64'(di), 64'(16));
        check("ignore_busy_cycles", 64'(bc), 64'(16));
        check("ignore_done_pulses", 64'(dc), 64'(1));
        check("ignore_P_hold", 64'(P), 64'(32'h0000_000F));

        // Start held high through DONE: back-to-back operation
        d1 = -1; d2 = -1; p1 = '0; p2 = '0; gap_busy = 1'b0;
        @(negedge clk);
        A = 16'd3; B = 16'd5; start = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 60; n++) begin
            if (n == 16) begin A = 16'h0010; B = 16'h0010; end
            if (n == 17) begin start = 1'b0; gap_busy = busy; end
            if (done) begin
                if (d1 < 0) begin d1 = n; p1 = P; end
                else if (d2 < 0) begin d2 = n; p2 = P; end
            end
            @(negedge clk);
        end
        $display("b2b: first P=0x%08h at %0d, second P=0x%08h at %0d", p1, d1, p2, d2);
        check("b2b_first_P", 64'(p1), 64'(32'h0000_000F));
        check("b2b_first_at", 64'(d1), 64'(16));
        check("b2b_no_gap", 64'(gap_busy), 64'(1));
        check("b2b_second_P", 64'(p2), 64'(32'h0000_0100));
        check("b2b_second_at", 64'(d2), 64'(33));

        // Reset in the middle of RUN aborts without a done pulse
        dc = 0; bc = 0;
        @(negedge clk);
        A = 16'd9; B = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1; start = 1'b1; A = 16'd1; B = 16'd1;
        @(negedge clk);
        $display("rst_mid: busy=%0d done=%0d P=0x%08h", busy, done, P);
        check("rstmid_busy", 64'(busy), 64'(0));
        check("rstmid_done", 64'(done), 64'(0));
        check("rstmid_P", 64'(P), 64'(0));
        rst = 1'b0; start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (busy) bc++;
            if (done) dc++;
            @(negedge clk);
        end
        check("rstmid_no_done", 64'(dc), 64'(0));
        check("rstmid_stays_idle", 64'(bc), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter: WIDTH, 16, operand width; product is 2*WIDTH bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request pulse; sampled only while busy=0.
REQ-005 A  input  WIDTH  multiplicand, unsigned; captured when start is accepted.
REQ-006 B  input  WIDTH  multiplier, unsigned; captured when start is accepted.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  single-cycle pulse marking P valid.
REQ-009 P  output  2*WIDTH  product; holds its value until the next accepted start.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE, with binary encoding.
REQ-011 IDLE: start=1 at an edge SHALL capture A and B, clear the accumulator and the cycle counter, and go to RUN.
REQ-012 RUN: each edge SHALL perform one shift-add step: if the low multiplier bit is 1, hi = hi + multiplicand in a (WIDTH+1)-bit sum keeping the carry; then {carry,hi,lo} shifts right one bit; counter increments.
REQ-013 After exactly WIDTH RUN edges, the FSM SHALL load P with {hi,lo}, go to DONE, and assert done for that one cycle.
REQ-014 DONE: the next edge SHALL return to IDLE unless start=1, in which case that edge SHALL behave as REQ-011 (back-to-back operation).
REQ-015 Latency SHALL be fixed: start accepted at edge t gives done=1 in the cycle after edge t+WIDTH (17 cycles for WIDTH=16), independent of operand values.
REQ-016 busy SHALL be 1 in RUN only; start while busy=1 SHALL be ignored, and A/B changes during RUN SHALL NOT affect the result.
REQ-017 The result SHALL equal A*B exactly; no truncation or overflow is possible in 2*WIDTH bits.
REQ-018 Operands of 0 SHALL still take the full latency (no early termination).

Reset
REQ-019 rst=1 at an edge SHALL force the FSM to IDLE, P=0, busy=0, done=0, and clear the counter and internal registers, regardless of state.
REQ-020 Reset mid-RUN SHALL abort the operation with no done pulse; start sampled in the same cycle as rst SHALL be ignored.

Configuration
REQ-021 Macro MUL_SEQ_SIGNED_EN: when defined, the block SHALL add an input port sgn (1 bit, captured with A/B).
REQ-022 With the macro defined and sgn=1, A and B SHALL be treated as two's complement: the block multiplies their magnitudes and conditionally negates the result when loading P. Latency is unchanged.
REQ-023 Without the macro, the sgn port and the sign logic SHALL NOT exist, and behaviour SHALL be unsigned as in REQ-012..REQ-018.

Structure
REQ-024 The shared include file mul_defs.vh SHALL hold the state encodings (S_IDLE, S_RUN, S_DONE) and the default WIDTH.
REQ-025 One sub-module, mul_step, SHALL hold the combinational single-iteration shift-add datapath; mul_seq holds the FSM, counter and registers.
REQ-026 The counter SHALL be clog2(WIDTH)+1 bits wide so that WIDTH is reachable without wrap-around.

Verification
REQ-027 A=3, B=5, start 1 cycle -> busy for 16 cycles, done=1 exactly 17 cycles after the start edge, P=0x0000000F.
REQ-028 A=0xFFFF, B=0xFFFF -> P=0xFFFE0001; A=0, B=0x1234 -> P=0, same latency.
REQ-029 start pulsed again at RUN cycle 5 with A=7, B=7 -> ignored; first result delivered unchanged; P holds after done until the next start.
REQ-030 start held high through DONE -> new operation accepted on the DONE edge, second done exactly 17 cycles later, no idle gap.
REQ-031 rst asserted at RUN cycle 8 -> next cycle IDLE, P=0, busy=0, no done pulse.
REQ-032 With MUL_SEQ_SIGNED_EN: sgn=1, A=0xFFFE, B=0x0003 -> P=0xFFFFFFFA; sgn=1, A=0x8000, B=0x8000 -> P=0x40000000; sgn=0 -> unsigned results match REQ-027/028.
